// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO that feeds a UART transmitter.
// Bytes come in from the VRAM response stream over a valid/ready handshake.
// They are drained one at a time as single-cycle write strobes, issued only
// while the transmitter reports not-busy.
//
// Build option: define UART_TX_FIFO_OVERFLOW_EN to build the sticky overflow
// flag. Without it, overflow_o is tied low.
//
// Ports:
//   clock, reset         system clock; asynchronous active-high reset
//   write_data_i [7:0]   byte from producer
//   write_valid_i        producer offers write_data_i
//   write_ready_o        FIFO can accept a byte this cycle (combinational)
//   tx_busy_i            transmitter busy
//   tx_data_o [7:0]      byte to transmitter, held until the next pop
//   tx_write_o           one-cycle write strobe
//   count_o              occupancy, 0..2^DEPTH_LOG2
//   overflow_o           sticky: valid offered while not ready
module uart_tx_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [7:0]            write_data_i,
  input  logic                  write_valid_i,
  output logic                  write_ready_o,
  input  logic                  tx_busy_i,
  output logic [7:0]            tx_data_o,
  output logic                  tx_write_o,
  output logic [DEPTH_LOG2:0]   count_o,
  output logic                  overflow_o
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;

  typedef enum logic {IDLE, HOLD} state_t;

  state_t                state;
  state_t                state_next;
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wp;
  logic [DEPTH_LOG2-1:0] rp;
  logic [CW-1:0]         count;
  logic                  push;
  logic                  pop;

  // A full FIFO refuses a push even if a pop happens in the same cycle.
  assign write_ready_o = !reset && (count != CW'(DEPTH));
  assign push          = write_valid_i && write_ready_o;
  assign count_o       = count;

  // Drain FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state and pop decision. HOLD skips one cycle because the
  // transmitter raises busy one cycle after the strobe.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if ((count != '0) && !tx_busy_i) begin
          pop        = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Storage array; its contents need no reset.
  always_ff @(posedge clock) begin
    if (push) mem[wp] <= write_data_i;
  end

  // Pointers, occupancy and registered transmitter outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wp         <= '0;
      rp         <= '0;
      count      <= '0;
      tx_write_o <= 1'b0;
      tx_data_o  <= 8'h00;
    end else begin
      tx_write_o <= pop;
      if (pop) begin
        tx_data_o <= mem[rp];
        rp        <= rp + DEPTH_LOG2'(1);
      end
      if (push) wp <= wp + DEPTH_LOG2'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef UART_TX_FIFO_OVERFLOW_EN
  // Sticky flag for bytes the producer offered while the FIFO was full.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                overflow_o <= 1'b0;
    else if (write_valid_i && !write_ready_o) overflow_o <= 1'b1;
  end
`else
  assign overflow_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo (DEPTH_LOG2=2). A queue-based model predicts
// occupancy, ready, strobes, the strobed data and overflow on every cycle.
module tb_uart_tx_fifo;

  localparam int unsigned DL2   = 2;
  localparam int unsigned DEPTH = 2 ** DL2;
`ifdef UART_TX_FIFO_OVERFLOW_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic           clock;
  logic           reset;
  logic [7:0]     write_data_i;
  logic           write_valid_i;
  logic           write_ready_o;
  logic           tx_busy_i;
  logic [7:0]     tx_data_o;
  logic           tx_write_o;
  logic [DL2:0]   count_o;
  logic           overflow_o;

  uart_tx_fifo #(.DEPTH_LOG2(DL2)) dut (
    .clock         (clock),
    .reset         (reset),
    .write_data_i  (write_data_i),
    .write_valid_i (write_valid_i),
    .write_ready_o (write_ready_o),
    .tx_busy_i     (tx_busy_i),
    .tx_data_o     (tx_data_o),
    .tx_write_o    (tx_write_o),
    .count_o       (count_o),
    .overflow_o    (overflow_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [7:0] q [$];
  logic [7:0] obs [$];
  logic [7:0] acc [$];
  logic [7:0] data_m;
  bit         last_pop;
  bit         ovf_m;
  // Transmitter busy model
  int         busy_cnt;
  bit         busy_delay;
  bit         force_busy;
  int         busy_len;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    last_pop   = 1'b0;
    ovf_m      = 1'b0;
    data_m     = 8'h00;
    busy_cnt   = 0;
    busy_delay = 1'b0;
  endtask

  // One clock cycle: drive inputs, predict, step the edge, compare.
  task automatic cycle(input bit v, input logic [7:0] d);
    bit ready_e;
    bit push_e;
    bit pop_e;
    bit busy_now;
    if (busy_delay) begin
      busy_now   = 1'b0;
      busy_delay = 1'b0;
    end else begin
      busy_now = (busy_cnt > 0);
      if (busy_cnt > 0) busy_cnt--;
    end
    busy_now      = busy_now | force_busy;
    write_valid_i = v;
    write_data_i  = d;
    tx_busy_i     = busy_now;
    ready_e = (q.size() < DEPTH);
    #1;
    check("ready", 32'(write_ready_o), 32'(ready_e));
    push_e = v && ready_e;
    // A pop needs data, an idle transmitter, and no pop on the previous edge.
    pop_e  = (q.size() != 0) && !busy_now && !last_pop;
    if (OVF_EN && v && !ready_e) ovf_m = 1'b1;
    @(posedge clock);
    #1;
    if (pop_e) data_m = q.pop_front();
    if (push_e) begin
      q.push_back(d);
      acc.push_back(d);
    end
    last_pop = pop_e;
    check("strobe", 32'(tx_write_o), 32'(pop_e));
    check("tx_data", 32'(tx_data_o), 32'(data_m));
    check("count", 32'(count_o), 32'(q.size()));
    check("overflow", 32'(overflow_o), 32'(ovf_m));
    if (tx_write_o === 1'b1) obs.push_back(tx_data_o);
    if (pop_e) begin
      busy_delay = 1'b1;
      busy_cnt   = busy_len;
    end
  endtask

  // Reset asserted asynchronously mid-cycle, held for n edges.
  task automatic do_reset(input int n);
    #2;
    reset = 1'b1;
    write_valid_i = 1'b0;
    #1;
    check("rst_count", 32'(count_o), 32'd0);
    check("rst_strobe", 32'(tx_write_o), 32'd0);
    check("rst_data", 32'(tx_data_o), 32'h00);
    check("rst_ready", 32'(write_ready_o), 32'd0);
    check("rst_ovf", 32'(overflow_o), 32'd0);
    model_clear();
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      check("rst_hold_ready", 32'(write_ready_o), 32'd0);
      check("rst_hold_strobe", 32'(tx_write_o), 32'd0);
      check("rst_hold_count", 32'(count_o), 32'd0);
    end
    reset = 1'b0;
    #1;
    check("rel_ready", 32'(write_ready_o), 32'd1);
  endtask

  task automatic check_obs(input string tag, input logic [7:0] exp [$]);
    check({tag, "_len"}, 32'(obs.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < obs.size(); i++)
      check(tag, 32'(obs[i]), 32'(exp[i]));
  endtask

  initial begin
    logic [7:0] exp [$];
    reset         = 1'b1;
    write_valid_i = 1'b0;
    write_data_i  = 8'h00;
    tx_busy_i     = 1'b0;
    force_busy    = 1'b0;
    busy_len      = 0;
    model_clear();

    // Reset release, empty
    do_reset(3);
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00);

    // Single byte: strobe exactly one cycle after the push edge
    obs.delete();
    busy_len = 2;
    cycle(1'b1, 8'hA5);
    cycle(1'b0, 8'h00);
    check("a5_strobe", 32'(tx_write_o), 32'd1);
    check("a5_data", 32'(tx_data_o), 32'hA5);
    cycle(1'b0, 8'h00);
    check("a5_width", 32'(tx_write_o), 32'd0);
    check("a5_count", 32'(count_o), 32'd0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00);
    exp = '{8'hA5};
    check_obs("a5_seq", exp);

    // Busy back-pressure: transmitter busy for 10 cycles after each strobe
    obs.delete();
    busy_len = 10;
    cycle(1'b1, 8'h01);
    cycle(1'b1, 8'h02);
    cycle(1'b1, 8'h03);
    for (int i = 0; i < 45; i++) cycle(1'b0, 8'h00);
    exp = '{8'h01, 8'h02, 8'h03};
    check_obs("bp_seq", exp);

    // Fill and wrap with busy held high
    obs.delete();
    busy_len   = 3;
    force_busy = 1'b1;
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'h10 + i));
    check("full_count", 32'(count_o), 32'd4);
    check("full_ready", 32'(write_ready_o), 32'd0);
    // Producer offers a byte while full
    cycle(1'b1, 8'hEE);
    check("ovf_flag", 32'(overflow_o), 32'(OVF_EN));
    check("ovf_count", 32'(count_o), 32'd4);
    cycle(1'b0, 8'h00);
    check("ovf_sticky", 32'(overflow_o), 32'(OVF_EN));
    force_busy = 1'b0;
    for (int i = 0; i < 20 && obs.size() == 0; i++) cycle(1'b0, 8'h00);
    check("first_pop_seen", 32'(obs.size()), 32'd1);
    cycle(1'b1, 8'h14);
    for (int i = 0; i < 40; i++) cycle(1'b0, 8'h00);
    exp = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
    check_obs("wrap_seq", exp);
    check("ovf_held", 32'(overflow_o), 32'(OVF_EN));

    // Reset mid-drain with 3 bytes queued and busy high
    force_busy = 1'b1;
    cycle(1'b1, 8'h31);
    cycle(1'b1, 8'h32);
    cycle(1'b1, 8'h33);
    check("pre_rst_count", 32'(count_o), 32'd3);
    do_reset(2);
    force_busy = 1'b0;
    obs.delete();
    for (int i = 0; i < 30; i++) cycle(1'b0, 8'h00);
    check("post_rst_strobes", 32'(obs.size()), 32'd0);

    // Random traffic with random transmitter busy periods
    obs.delete();
    acc.delete();
    for (int i = 0; i < 600; i++) begin
      busy_len = int'($urandom_range(0, 6));
      cycle(($urandom_range(0, 99) < 55), 8'($urandom));
    end
    busy_len = 2;
    for (int i = 0; i < 60; i++) cycle(1'b0, 8'h00);
    check("rand_drained", 32'(count_o), 32'd0);
    check_obs("rand_seq", acc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net against a stalled run.
  initial begin
    #500000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
